// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path and its CPU-side FIFO.
package kbd_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Line levels of the framing bits
  localparam logic START = 1'b0;
  localparam logic STOP  = 1'b1;

  // key_data field positions
  localparam int KD_BYTE_LSB = 0;
  localparam int KD_BYTE_MSB = 7;
  localparam int KD_VALID    = 8;
  localparam int KD_OVF      = 9;

  // High when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/kbd_fifo_rx_ps2_rx.sv
// PS/2 serial receiver: pin synchronisers, falling-edge detect, frame FSM and
// inactivity timeout. Emits one registered byte_valid or frame_err pulse per frame.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int            TW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          clk_prev_r;
  logic          fall_s;
  logic          bit_s;
  logic          timeout_s;
  rx_state_t     state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] idle_cnt_r;

  // Two-flop synchronisers on both pins plus a third flop for clock edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  assign fall_s    = clk_prev_r & ~clk_sync_r[1];
  assign bit_s     = data_sync_r[1];
  // A falling edge in the same cycle wins over the timeout
  assign timeout_s = (state_r != RX_IDLE) && !fall_s && (idle_cnt_r == TIMEOUT_LIMIT);

  // Counts cycles since the last falling edge while a frame is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_r <= {TW{1'b0}};
    end else if ((state_r == RX_IDLE) || fall_s) begin
      idle_cnt_r <= {TW{1'b0}};
    end else if (idle_cnt_r != TIMEOUT_LIMIT) begin
      idle_cnt_r <= idle_cnt_r + TW'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // Frame FSM: sample on falling edges, check parity/stop, pulse result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RX_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout_s) begin
        // Abandon the partial frame silently
        state_r   <= RX_IDLE;
        bit_cnt_r <= 3'd0;
        shift_r   <= 8'h00;
      end else if (fall_s) begin
        case (state_r)
          RX_IDLE: begin
            if (bit_s == START) begin
              state_r   <= RX_DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          RX_DATA: begin
            shift_r   <= {bit_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= RX_PARITY;
            end
          end
          RX_PARITY: begin
            parity_r <= bit_s;
            state_r  <= RX_STOP;
          end
          RX_STOP: begin
            state_r <= RX_IDLE;
            if ((bit_s == STOP) && odd_parity_ok(shift_r, parity_r)) begin
              rx_byte    <= shift_r;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state_r <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/kbd_fifo_rx.sv
// Keyboard receive block: PS/2 receiver feeding a scancode FIFO that the CPU
// reads through key_data; one entry is popped per rising edge of read_key.
module kbd_fifo_rx
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        read_key,
  output logic [31:0] key_data,
  output logic        frame_err
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic          overflow_r;
  logic          read_prev_r;
  logic          read_rise_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // A pop needs data present; a push into a full FIFO only lands if a pop frees a slot
  assign read_rise_s = read_key & ~read_prev_r;
  assign empty_s     = (count_r == {(AW + 1){1'b0}});
  assign full_s      = (count_r == CNT_FULL);
  assign pop_s       = read_rise_s & ~empty_s;
  assign push_s      = byte_valid & (~full_s | pop_s);
  assign drop_s      = byte_valid & full_s & ~pop_s;

  // Scancode storage, written at the tail
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rx_byte;
    end
  end

  // Pointers, occupancy, sticky overflow and read_key history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW + 1){1'b0}};
      overflow_r  <= 1'b0;
      read_prev_r <= 1'b0;
    end else begin
      read_prev_r <= read_key;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (read_rise_s) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // CPU view of the FIFO head, built from registered state
  always_comb begin
    key_data           = 32'h0000_0000;
    key_data[KD_VALID] = ~empty_s;
    key_data[KD_OVF]   = overflow_r;
    if (!empty_s) begin
      key_data[KD_BYTE_MSB:KD_BYTE_LSB] = mem_r[rd_ptr_r];
    end else begin
      key_data[KD_BYTE_MSB:KD_BYTE_LSB] = 8'h00;
    end
  end

endmodule

// File: tb/tb_kbd_fifo_rx.sv
// Bench for kbd_fifo_rx: directed scenarios plus randomized PS/2 traffic and
// CPU reads, compared every cycle against a queue-based model of the FIFO.
module tb_kbd_fifo_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        read_key = 1'b0;
  logic [31:0] key_data;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ferr_seen = 0;
  bit done = 1'b0;

  // Event schedules, indexed by cycle modulo 64; an entry matches when it holds that cycle number
  int         push_at [64] = '{default: -1};
  logic [7:0] push_val [64];
  int         pop_at  [64] = '{default: -1};
  int         ferr_at [64] = '{default: -1};

  // Reference model state
  logic [7:0] mq [$];
  bit         ovf_m = 1'b0;

  kbd_fifo_rx #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .read_key (read_key),
    .key_data (key_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: apply scheduled pushes/pops to a plain queue at each clock edge
  always @(posedge clk) begin
    int  s;
    bit  pu;
    bit  po;
    bit  pe;
    int  sz;
    cyc = cyc + 1;
    s = cyc % 64;
    if (rst) begin
      mq.delete();
      ovf_m = 1'b0;
    end else begin
      pu = (push_at[s] == cyc);
      po = (pop_at[s] == cyc);
      sz = mq.size();
      pe = po && (sz > 0);
      if (po) ovf_m = 1'b0;
      if (pe) void'(mq.pop_front());
      if (pu) begin
        if (sz == DEPTH && !pe) ovf_m = 1'b1;
        else mq.push_back(push_val[s]);
      end
    end
  end

  // Compare DUT outputs to the model every cycle, away from the active edge
  always @(negedge clk) begin
    logic [31:0] exp_kd;
    logic        exp_fe;
    bit          ne;
    if (rst) begin
      exp_kd = 32'h0;
      exp_fe = 1'b0;
    end else begin
      ne = (mq.size() != 0);
      exp_kd = {22'd0, ovf_m, ne, (ne ? mq[0] : 8'h00)};
      exp_fe = (ferr_at[cyc % 64] == cyc);
    end
    chk("key_data", key_data, exp_kd);
    chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
    if (frame_err) ferr_seen++;
  end

  // Send nbits of a PS/2 frame (start, 8 data LSB first, parity, stop); optionally
  // raise read_key so the pop lands on the same edge as the resulting push
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit sync_read, input int nbits);
    logic [10:0] bits;
    int n;
    bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ps2_data = bits[i];
      repeat (4) @(posedge clk);
      #1;
      ps2_clk = 1'b0;
      n = cyc;
      if (i == 10) begin
        if (bad_par || bad_stop) begin
          ferr_at[(n + 3) % 64] = n + 3;
        end else begin
          push_at[(n + 4) % 64]  = n + 4;
          push_val[(n + 4) % 64] = b;
        end
      end
      if (i == 10 && sync_read) begin
        repeat (3) @(posedge clk);
        #1;
        read_key = 1'b1;
        pop_at[(cyc + 1) % 64] = cyc + 1;
        @(posedge clk); #1;
        ps2_clk = 1'b1;
        @(posedge clk); #1;
        read_key = 1'b0;
      end else begin
        repeat (4) @(posedge clk);
        #1;
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
  endtask

  // One read_key pulse held for 'hold' cycles
  task automatic pulse_read(input int hold);
    @(posedge clk); #1;
    read_key = 1'b1;
    pop_at[(cyc + 1) % 64] = cyc + 1;
    repeat (hold) @(posedge clk);
    #1;
    read_key = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int e0;
    // Reset state
    settle(3);
    chk("reset_key_data", key_data, 32'h0000_0000);
    chk("reset_frame_err", {31'd0, frame_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    settle(3);

    // Single good frame, held read pops once
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11);
    settle(3);
    chk("frame_1c", key_data, 32'h0000_011C);
    pulse_read(3);
    settle(2);
    chk("after_read_1c", key_data, 32'h0000_0000);

    // Bad parity frame
    e0 = ferr_seen;
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 11);
    settle(6);
    chk("bad_parity_pulses", 32'(ferr_seen - e0), 32'd1);
    chk("bad_parity_kd", key_data, 32'h0000_0000);

    // Nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 11);
    settle(3);
    chk("overflow_kd", key_data, 32'h0000_0301);
    for (int i = 1; i <= 8; i++) begin
      settle(1);
      chk("drain_head", {24'd0, key_data[7:0]}, 32'(i));
      pulse_read(1);
      settle(2);
      if (i == 1) chk("ovf_cleared", key_data, 32'h0000_0102);
    end
    chk("drained", key_data, 32'h0000_0000);

    // Partial frame abandoned by timeout, then a clean frame
    e0 = ferr_seen;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 5);
    repeat (TMO + 100) @(posedge clk);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 11);
    settle(3);
    chk("timeout_then_29", key_data, 32'h0000_0129);
    chk("timeout_no_ferr", 32'(ferr_seen - e0), 32'd0);
    pulse_read(1);
    settle(2);

    // Full FIFO, push and pop on the same edge
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 11);
    settle(2);
    chk("full_kd", key_data, 32'h0000_0110);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 11);
    settle(2);
    chk("full_push_pop", key_data, 32'h0000_0111);
    for (int i = 0; i < 7; i++) begin
      pulse_read(1);
      settle(1);
    end
    settle(1);
    chk("last_is_5a", key_data, 32'h0000_015A);
    pulse_read(1);
    settle(2);
    chk("empty_again", key_data, 32'h0000_0000);

    // Reset in the middle of a frame
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    settle(1);
    chk("midframe_rst_kd", key_data, 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 11);
    settle(3);
    chk("after_rst_33", key_data, 32'h0000_0133);
    pulse_read(1);
    settle(2);

    // Randomized frames (some corrupted) against random CPU reads
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int r;
          r = $urandom_range(0, 9);
          send_frame(8'($urandom_range(0, 255)), r == 0, r == 1, 1'b0, 11);
          repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          repeat ($urandom_range(30, 300)) begin
            if (!done) @(posedge clk);
          end
          if (!done) pulse_read($urandom_range(1, 3));
        end
      end
    join
    for (int k = 0; k < 20 && (mq.size() > 0 || ovf_m); k++) begin
      pulse_read(1);
      settle(1);
    end
    settle(2);
    chk("final_empty", key_data, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_fifo_rx.md
KBD_FIFO_RX -- requirements
Module: kbd_fifo_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scancode buffer entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock, the single clock of the block.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the pin, asynchronous.
REQ-007 SHALL have port read_key  input  1  level, high while the CPU address decodes to the keyboard region (0x003xxxxx).
REQ-008 SHALL have port key_data  output  32  {22'b0, overflow, valid, scancode[7:0]}, read by the CPU.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse per discarded frame.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers; a falling edge is detected on the synchronised ps2_clk with a third flop.
REQ-011 SHALL sample synchronised ps2_data only on detected falling edges.
REQ-012 SHALL run receiver FSM states IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay IDLE.
REQ-014 DATA: shift bits in LSB first; after the 8th bit -> PARITY.
REQ-015 PARITY: record the bit -> STOP.
REQ-016 STOP: sampled 1 and odd parity over 8 data bits plus parity bit -> push byte, -> IDLE; otherwise pulse frame_err, no push, -> IDLE.
REQ-017 SHALL count clk cycles since the last falling edge while not in IDLE; on reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE, discard the partial byte, no frame_err.
REQ-018 Push SHALL occur on the clk edge after the stop-bit falling edge is detected; key_data SHALL reflect the byte in the following cycle.
REQ-019 SHALL pop exactly one entry per rising edge of read_key (registered previous value); a held read_key pops once.
REQ-020 key_data[7:0] SHALL be the FIFO head when valid, else 0x00; key_data[8] SHALL equal FIFO non-empty; key_data is combinational from registered state.
REQ-021 Push when full with no simultaneous pop SHALL drop the new byte and set sticky overflow (key_data[9]).
REQ-022 Push and pop in the same cycle when full SHALL both take effect; count unchanged, no overflow.
REQ-023 Push and pop in the same cycle when empty SHALL ignore the pop and store the byte.
REQ-024 Overflow SHALL clear on a read_key rising edge, together with that pop.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-026 rst SHALL asynchronously force FSM to IDLE, bit count, shift register, timeout counter, pointers, count, overflow, read_key history and synchronisers (to 1) to reset values.
REQ-027 During/after reset key_data SHALL read 0x00000000 and frame_err 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next start bit after reset release begins a new frame.

Structure
REQ-029 Package kbd_pkg SHALL hold the FSM state typedef, frame bit constants (START=0, STOP=1) and the key_data field positions.
REQ-030 Receiver (synchronisers, FSM, timeout) SHALL be sub-module ps2_rx with outputs byte[7:0], byte_valid pulse and frame_err; FIFO and CPU-side logic live in kbd_fifo_rx.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 -> key_data = 0x0000011C; read_key high 3 cycles -> one pop, key_data = 0x00000000.
REQ-032 Frame 0xF0 with parity 0 (bad) -> one frame_err pulse, key_data stays 0x00000000.
REQ-033 Nine frames 0x01..0x09, no reads -> key_data = 0x00000301; eight read_key pulses return 0x01..0x08; overflow clears on first read.
REQ-034 5 bits then ps2_clk idle > TIMEOUT_CYCLES, then frame 0x29 -> key_data = 0x00000129, no frame_err.
REQ-035 FIFO full, frame 0x5A completes in the same cycle as a read_key rising edge -> head advances, 0x5A stored as last entry, overflow 0.
REQ-036 rst asserted after 4 data bits of a frame, released, then frame 0x33 -> key_data = 0x00000133.
